// File: rtl/tmr_scrub_register.sv
// rtl/tmr_scrub_register.sv - triplicated register with majority vote, lane error flags and periodic scrub
module tmr_scrub_register #(
    parameter int WIDTH        = 8,
    parameter int CNT_WIDTH    = 8,
    parameter int SCRUB_PERIOD = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WIDTH-1:0]     dataIn,
    input  logic                 scrubEn,
    input  logic                 clrErr,
    input  logic                 injEn,
    input  logic [1:0]           injLane,
    input  logic [WIDTH-1:0]     injMask,
    output logic [WIDTH-1:0]     out,
    output logic                 tmrErr,
    output logic [2:0]           laneErr,
    output logic [CNT_WIDTH-1:0] errCnt,
    output logic                 scrubActive
);

    localparam int PW = (SCRUB_PERIOD > 2) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [PW-1:0] LAST_WAIT = PW'(SCRUB_PERIOD - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SCRUB = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     copy_q [3];
    logic [WIDTH-1:0]     copy_d [3];
    logic                 tmr_err_q, tmr_err_d;
    logic [2:0]           lane_err_q, lane_err_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0]     voted;
    logic [2:0]           mis;
    logic                 any_mis;
    logic                 scrub_wb;

    always_comb begin
        voted = (copy_q[0] & copy_q[1]) | (copy_q[1] & copy_q[2]) | (copy_q[0] & copy_q[2]);
        for (int i = 0; i < 3; i++) begin
            mis[i] = |(copy_q[i] ^ voted);
        end
        any_mis  = |mis;
        // A load landing on the scrub cycle pre-empts the write-back entirely
        scrub_wb = (state_q == SCRUB) && !load;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (scrubEn) state_d = WAIT;
            end
            WAIT: begin
                if (!scrubEn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (load) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = SCRUB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            SCRUB: begin
                cnt_d   = '0;
                state_d = scrubEn ? WAIT : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            copy_d[i] = copy_q[i];
        end
        if (load) begin
            for (int i = 0; i < 3; i++) copy_d[i] = dataIn;
        end else if (scrub_wb) begin
            for (int i = 0; i < 3; i++) copy_d[i] = voted;
        end else if (injEn) begin
            case (injLane)
                2'd0:    copy_d[0] = copy_q[0] ^ injMask;
                2'd1:    copy_d[1] = copy_q[1] ^ injMask;
                2'd2:    copy_d[2] = copy_q[2] ^ injMask;
                default: copy_d[0] = copy_q[0];
            endcase
        end
    end

    always_comb begin
        tmr_err_d  = any_mis;
        lane_err_d = clrErr ? 3'b000 : (lane_err_q | mis);
        err_cnt_d  = err_cnt_q;
        if (clrErr) begin
            err_cnt_d = '0;
        end else if (scrub_wb && any_mis && (err_cnt_q != {CNT_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tmr_err_q  <= 1'b0;
            lane_err_q <= 3'b000;
            err_cnt_q  <= '0;
            for (int i = 0; i < 3; i++) copy_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmr_err_q  <= tmr_err_d;
            lane_err_q <= lane_err_d;
            err_cnt_q  <= err_cnt_d;
            for (int i = 0; i < 3; i++) copy_q[i] <= copy_d[i];
        end
    end

    assign out         = voted;
    assign tmrErr      = tmr_err_q;
    assign laneErr     = lane_err_q;
    assign errCnt      = err_cnt_q;
    assign scrubActive = scrub_wb;

endmodule

// File: tb/tb_tmr_scrub_register.sv
// tb/tb_tmr_scrub_register.sv - randomized self-checking bench for tmr_scrub_register
module tb_tmr_scrub_register;

    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 2;
    localparam int SP        = 16;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 reset, load, scrubEn, clrErr, injEn;
    logic [WIDTH-1:0]     dataIn, injMask;
    logic [1:0]           injLane;
    logic [WIDTH-1:0]     out;
    logic                 tmrErr, scrubActive;
    logic [2:0]           laneErr;
    logic [CNT_WIDTH-1:0] errCnt;

    always #5 clk = ~clk;

    tmr_scrub_register #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .SCRUB_PERIOD(SP)) dut (
        .clk(clk), .reset(reset), .load(load), .dataIn(dataIn), .scrubEn(scrubEn),
        .clrErr(clrErr), .injEn(injEn), .injLane(injLane), .injMask(injMask),
        .out(out), .tmrErr(tmrErr), .laneErr(laneErr), .errCnt(errCnt),
        .scrubActive(scrubActive)
    );

    // Reference model: three stored words, error bookkeeping, and the age of the scrub timer
    logic [WIDTH-1:0] mc [3];
    logic             m_tmr;
    logic [2:0]       m_lane;
    int               m_cnt;
    bit               m_run;
    int               m_age;
    bit               exp_active, obs_active;
    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;

    function automatic logic [WIDTH-1:0] vote_of(input logic [WIDTH-1:0] a, b, c);
        logic [WIDTH-1:0] v;
        for (int k = 0; k < WIDTH; k++) begin
            int ones;
            ones = int'(a[k]) + int'(b[k]) + int'(c[k]);
            v[k] = (ones >= 2);
        end
        return v;
    endfunction

    task automatic model_step();
        logic [WIDTH-1:0] v;
        logic [2:0]       m;
        bit               scrub_now;
        v = vote_of(mc[0], mc[1], mc[2]);
        for (int i = 0; i < 3; i++) m[i] = (mc[i] != v);
        scrub_now = m_run && (m_age == SP - 1) && !load;
        if (reset) begin
            for (int i = 0; i < 3; i++) mc[i] = '0;
            m_tmr = 0; m_lane = 0; m_cnt = 0; m_run = 0; m_age = 0;
        end else begin
            m_tmr  = (m != 0);
            m_lane = clrErr ? 3'b000 : (m_lane | m);
            if (clrErr) m_cnt = 0;
            else if (scrub_now && m != 0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (load) begin
                for (int i = 0; i < 3; i++) mc[i] = dataIn;
            end else if (scrub_now) begin
                for (int i = 0; i < 3; i++) mc[i] = v;
            end else if (injEn && injLane != 2'd3) begin
                mc[injLane] = mc[injLane] ^ injMask;
            end
            if (!m_run) begin
                m_run = scrubEn; m_age = 0;
            end else if (!scrubEn) begin
                m_run = 0; m_age = 0;
            end else if (load || m_age == SP - 1) begin
                m_age = 0;
            end else begin
                m_age = m_age + 1;
            end
        end
    endtask

    task automatic tick();
        exp_active = m_run && (m_age == SP - 1) && !load;
        @(negedge clk);
        obs_active = scrubActive;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic quiet();
        reset = 0; load = 0; clrErr = 0; injEn = 0; injLane = 0; injMask = 0;
    endtask

    task automatic wait_scrub_next();
        for (int i = 0; i < 2 * SP && !(m_run && m_age == SP - 1); i++) tick();
        checks++;
        if (!(m_run && m_age == SP - 1)) begin
            errors++;
            $display("FAIL wait_scrub: scrub cycle not reached in %0d cycles (run=%0d age=%0d)", 2 * SP, m_run, m_age);
        end
    endtask

    task automatic test_reset();
        quiet();
        scrubEn = 1; reset = 1; load = 1; dataIn = 8'($urandom);
        injEn = 1; injLane = 0; injMask = 8'hFF;
        tick(); tick();
        checks += 5;
        if (out !== 8'h00)    begin errors++; $display("FAIL reset_out: got %h expected 00", out); end
        if (tmrErr !== 1'b0)  begin errors++; $display("FAIL reset_tmr: got %b expected 0", tmrErr); end
        if (laneErr !== 3'b0) begin errors++; $display("FAIL reset_lane: got %b expected 000", laneErr); end
        if (errCnt !== '0)    begin errors++; $display("FAIL reset_cnt: got %0d expected 0", errCnt); end
        if (obs_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", obs_active); end
        quiet(); scrubEn = 0;
        tick();
    endtask

    task automatic test_load();
        load = 1; dataIn = 8'hA5;
        tick();
        quiet();
        checks += 4;
        if (out !== 8'hA5 || out !== vote_of(mc[0], mc[1], mc[2]))
            begin errors++; $display("FAIL load_out: got %h expected a5", out); end
        if (tmrErr !== m_tmr)  begin errors++; $display("FAIL load_tmr: got %b expected %b", tmrErr, m_tmr); end
        if (laneErr !== m_lane) begin errors++; $display("FAIL load_lane: got %b expected %b", laneErr, m_lane); end
        if (int'(errCnt) !== m_cnt) begin errors++; $display("FAIL load_cnt: got %0d expected %0d", errCnt, m_cnt); end
    endtask

    task automatic test_inject_single();
        scrubEn = 0; load = 1; dataIn = 8'h3C;
        tick();
        quiet(); injEn = 1; injLane = 1; injMask = 8'h01;
        tick();
        quiet();
        checks += 2;
        if (out !== 8'h3C) begin errors++; $display("FAIL inj_out: got %h expected 3c", out); end
        if (tmrErr !== m_tmr) begin errors++; $display("FAIL inj_tmr_early: got %b expected %b", tmrErr, m_tmr); end
        tick();
        checks += 2;
        if (tmrErr !== 1'b1 || tmrErr !== m_tmr) begin errors++; $display("FAIL inj_tmr: got %b expected 1", tmrErr); end
        if (laneErr !== 3'b010) begin errors++; $display("FAIL inj_lane: got %b expected 010", laneErr); end
        repeat (3) tick();
        checks++;
        if (laneErr !== m_lane) begin errors++; $display("FAIL inj_lane_hold: got %b expected %b", laneErr, m_lane); end
        clrErr = 1;
        tick();
        quiet();
        checks++;
        if (laneErr !== m_lane) begin errors++; $display("FAIL inj_lane_clr: got %b expected %b", laneErr, m_lane); end
    endtask

    task automatic test_scrub_correct();
        int pulses_obs, pulses_exp;
        load = 1; dataIn = 8'h00; scrubEn = 1; clrErr = 1;
        tick();
        quiet(); injEn = 1; injLane = 2; injMask = 8'hFF;
        tick();
        quiet();
        pulses_obs = 0; pulses_exp = 0;
        for (int i = 0; i < SP; i++) begin
            tick();
            pulses_obs += int'(obs_active);
            pulses_exp += int'(exp_active);
            if (exp_active) begin
                checks += 2;
                if (dut.copy_q[2] !== mc[2] || mc[2] !== 8'h00)
                    begin errors++; $display("FAIL scrub_copy_c: got %h expected 00", dut.copy_q[2]); end
                if (int'(errCnt) !== m_cnt) begin errors++; $display("FAIL scrub_cnt: got %0d expected %0d", errCnt, m_cnt); end
                tick();
                checks++;
                if (tmrErr !== 1'b0) begin errors++; $display("FAIL scrub_tmr: got %b expected 0", tmrErr); end
            end
        end
        checks++;
        if (pulses_obs !== 1 || pulses_obs !== pulses_exp)
            begin errors++; $display("FAIL scrub_pulses: got %0d expected %0d", pulses_obs, pulses_exp); end
    endtask

    task automatic test_periodic();
        int last, pulses;
        quiet(); scrubEn = 1;
        last = -1; pulses = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            checks++;
            if (obs_active !== exp_active)
                begin errors++; $display("FAIL periodic_active: cycle %0d got %b expected %b", cyc, obs_active, exp_active); end
            if (obs_active) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== SP) begin errors++; $display("FAIL periodic_gap: got %0d expected %0d", cyc - last, SP); end
                end
                last = cyc; pulses++;
            end
        end
        checks += 2;
        if (pulses !== 4) begin errors++; $display("FAIL periodic_count: got %0d expected 4", pulses); end
        if (int'(errCnt) !== m_cnt) begin errors++; $display("FAIL periodic_cnt: got %0d expected %0d", errCnt, m_cnt); end
    endtask

    task automatic test_double_fault();
        logic [WIDTH-1:0] d;
        quiet(); scrubEn = 0;
        tick();
        d = 8'($urandom);
        load = 1; dataIn = d;
        tick();
        quiet(); injEn = 1; injLane = 0; injMask = 8'h0F;
        tick();
        injLane = 1; clrErr = 1;
        tick();
        quiet();
        tick();
        checks += 2;
        if (out !== (d ^ 8'h0F)) begin errors++; $display("FAIL double_out: got %h expected %h", out, d ^ 8'h0F); end
        if (laneErr !== 3'b100 || laneErr !== m_lane) begin errors++; $display("FAIL double_lane: got %b expected 100", laneErr); end
        scrubEn = 1;
        wait_scrub_next();
        tick();
        checks += 2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut.copy_q[i] !== (d ^ 8'h0F))
                begin errors++; $display("FAIL double_copy%0d: got %h expected %h", i, dut.copy_q[i], d ^ 8'h0F); end
        end
        if (obs_active !== 1'b1) begin errors++; $display("FAIL double_active: got %b expected 1", obs_active); end
        if (int'(errCnt) !== m_cnt) begin errors++; $display("FAIL double_cnt: got %0d expected %0d", errCnt, m_cnt); end
    endtask

    task automatic test_load_in_scrub();
        int cnt_before, start, gap;
        quiet(); scrubEn = 1;
        wait_scrub_next();
        tick();
        injEn = 1; injLane = 0; injMask = 8'($urandom_range(1, 255));
        tick();
        quiet();
        wait_scrub_next();
        cnt_before = int'(errCnt);
        load = 1; dataIn = 8'h55;
        tick();
        quiet();
        start = cyc;
        checks += 2;
        if (obs_active !== 1'b0) begin errors++; $display("FAIL lis_active: got %b expected 0", obs_active); end
        if (int'(errCnt) !== cnt_before || int'(errCnt) !== m_cnt)
            begin errors++; $display("FAIL lis_cnt: got %0d expected %0d", errCnt, cnt_before); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut.copy_q[i] !== 8'h55) begin errors++; $display("FAIL lis_copy%0d: got %h expected 55", i, dut.copy_q[i]); end
        end
        gap = -1;
        for (int i = 0; i < 2 * SP && gap < 0; i++) begin
            tick();
            if (obs_active) gap = cyc - start;
        end
        checks++;
        if (gap !== SP) begin errors++; $display("FAIL lis_next_scrub: got %0d expected %0d", gap, SP); end
    endtask

    task automatic test_saturation();
        quiet(); scrubEn = 1; clrErr = 1;
        tick();
        quiet();
        wait_scrub_next();
        tick();
        for (int k = 1; k <= 5; k++) begin
            injEn = 1; injLane = 2'($urandom_range(0, 2)); injMask = 8'($urandom_range(1, 255));
            tick();
            quiet();
            wait_scrub_next();
            tick();
            checks++;
            if (int'(errCnt) !== ((k < CNT_MAX) ? k : CNT_MAX) || int'(errCnt) !== m_cnt)
                begin errors++; $display("FAIL sat_cnt%0d: got %0d expected %0d", k, errCnt, (k < CNT_MAX) ? k : CNT_MAX); end
        end
        injEn = 1; injLane = 1; injMask = 8'h80;
        tick();
        quiet();
        wait_scrub_next();
        clrErr = 1;
        tick();
        quiet();
        checks += 2;
        if (obs_active !== 1'b1) begin errors++; $display("FAIL sat_clr_active: got %b expected 1", obs_active); end
        if (errCnt !== '0) begin errors++; $display("FAIL sat_clr_cnt: got %0d expected 0", errCnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 99) == 0);
            load    = ($urandom_range(0, 15) == 0);
            dataIn  = 8'($urandom);
            scrubEn = ($urandom_range(0, 7) != 0);
            clrErr  = ($urandom_range(0, 19) == 0);
            injEn   = ($urandom_range(0, 3) == 0);
            injLane = 2'($urandom_range(0, 3));
            injMask = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            tick();
            checks += 5;
            if (out !== vote_of(mc[0], mc[1], mc[2]))
                begin errors++; $display("FAIL rand_out: cycle %0d got %h expected %h", cyc, out, vote_of(mc[0], mc[1], mc[2])); end
            if (tmrErr !== m_tmr) begin errors++; $display("FAIL rand_tmr: cycle %0d got %b expected %b", cyc, tmrErr, m_tmr); end
            if (laneErr !== m_lane) begin errors++; $display("FAIL rand_lane: cycle %0d got %b expected %b", cyc, laneErr, m_lane); end
            if (int'(errCnt) !== m_cnt) begin errors++; $display("FAIL rand_cnt: cycle %0d got %0d expected %0d", cyc, errCnt, m_cnt); end
            if (obs_active !== exp_active)
                begin errors++; $display("FAIL rand_active: cycle %0d got %b expected %b", cyc, obs_active, exp_active); end
        end
        quiet();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) mc[i] = '0;
        m_tmr = 0; m_lane = 0; m_cnt = 0; m_run = 0; m_age = 0;
        quiet(); scrubEn = 0; dataIn = 0;
        reset = 1;
        test_reset();
        test_load();
        test_inject_single();
        test_scrub_correct();
        test_periodic();
        test_double_fault();
        test_load_in_scrub();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
